// File: rtl/mempool_dma_frontend.sv
// rtl/mempool_dma_frontend.sv - register-programmed DMA burst request frontend
// Builds one cluster DMA request per NEXT_ID read and tracks outstanding/completed transfers.
module mempool_dma_frontend #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned IdWidth        = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   reg_req_i,
  input  logic                   reg_we_i,
  input  logic [4:0]             reg_addr_i,
  input  logic [DataWidth-1:0]   reg_wdata_i,
  input  logic [DataWidth/8-1:0] reg_be_i,
  output logic                   reg_rvalid_o,
  output logic [DataWidth-1:0]   reg_rdata_o,
  output logic [AddrWidth-1:0]   dma_src_o,
  output logic [AddrWidth-1:0]   dma_dst_o,
  output logic [AddrWidth-1:0]   dma_num_bytes_o,
  output logic                   dma_valid_o,
  input  logic                   dma_ready_i,
  input  logic                   dma_trans_complete_i,
  input  logic                   dma_backend_idle_i
);

  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
  localparam int unsigned BeW  = DataWidth / 8;

  localparam logic [2:0] IdxSrc    = 3'd0;
  localparam logic [2:0] IdxDst    = 3'd1;
  localparam logic [2:0] IdxLen    = 3'd2;
  localparam logic [2:0] IdxStatus = 3'd3;
  localparam logic [2:0] IdxNextId = 3'd4;
  localparam logic [2:0] IdxDone   = 3'd5;

  logic [AddrWidth-1:0] src_q, dst_q, len_q;
  logic [AddrWidth-1:0] dma_src_q, dma_dst_q, dma_len_q;
  logic                 dma_valid_q;
  logic [IdWidth-1:0]   next_id_q, done_id_q;
  logic [OutW-1:0]      outstanding_q;
  logic                 rvalid_q;
  logic [DataWidth-1:0] rdata_q;

  logic                 wr_req, rd_req;
  logic [2:0]           reg_idx;
  logic [DataWidth-1:0] be_mask;
  logic [OutW:0]        in_flight;
  logic                 launch_ok, launch;
  logic                 handshake;
  logic                 busy;
  logic [IdWidth-1:0]   next_id_inc, done_id_inc;
  logic [DataWidth-1:0] rdata_d;

  assign wr_req  = reg_req_i & reg_we_i;
  assign rd_req  = reg_req_i & ~reg_we_i;
  assign reg_idx = reg_addr_i[4:2];

  always_comb begin
    be_mask = '0;
    for (int i = 0; i < BeW; i++) begin
      be_mask[i*8 +: 8] = {8{reg_be_i[i]}};
    end
  end

  // A request still waiting for its handshake counts against the outstanding budget.
  assign in_flight = (OutW+1)'(outstanding_q) + (OutW+1)'(dma_valid_q);
  assign launch_ok = ~dma_valid_q && (len_q != '0) && (in_flight < (OutW+1)'(MaxOutstanding));
  assign launch    = rd_req && (reg_idx == IdxNextId) && launch_ok;
  assign handshake = dma_valid_q & dma_ready_i;
  assign busy      = dma_valid_q | (outstanding_q != '0) | ~dma_backend_idle_i;

  // ID 0 is reserved as the "rejected" read value, so both counters skip it on wrap.
  assign next_id_inc = (next_id_q == '1) ? IdWidth'(1) : next_id_q + IdWidth'(1);
  assign done_id_inc = (done_id_q == '1) ? IdWidth'(1) : done_id_q + IdWidth'(1);

  always_comb begin
    rdata_d = '0;
    if (rd_req) begin
      case (reg_idx)
        IdxSrc:    rdata_d = src_q;
        IdxDst:    rdata_d = dst_q;
        IdxLen:    rdata_d = len_q;
        IdxStatus: rdata_d = {{(DataWidth-2){1'b0}}, dma_valid_q, busy};
        IdxNextId: rdata_d = launch ? DataWidth'(next_id_q) : '0;
        IdxDone:   rdata_d = DataWidth'(done_id_q);
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= reg_req_i;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
    end else if (wr_req) begin
      case (reg_idx)
        IdxSrc:  src_q <= (src_q & ~be_mask) | (reg_wdata_i & be_mask);
        IdxDst:  dst_q <= (dst_q & ~be_mask) | (reg_wdata_i & be_mask);
        IdxLen:  len_q <= (len_q & ~be_mask) | (reg_wdata_i & be_mask);
        default: ;
      endcase
    end
  end

  // Payload is captured only on launch, so later register writes cannot disturb a pending request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dma_valid_q <= 1'b0;
      dma_src_q   <= '0;
      dma_dst_q   <= '0;
      dma_len_q   <= '0;
      next_id_q   <= IdWidth'(1);
    end else if (launch) begin
      dma_valid_q <= 1'b1;
      dma_src_q   <= src_q;
      dma_dst_q   <= dst_q;
      dma_len_q   <= len_q;
      next_id_q   <= next_id_inc;
    end else if (handshake) begin
      dma_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      done_id_q     <= '0;
    end else begin
      if (dma_trans_complete_i) begin
        done_id_q <= done_id_inc;
      end
      case ({handshake, dma_trans_complete_i})
        2'b10:   outstanding_q <= outstanding_q + OutW'(1);
        2'b01:   if (outstanding_q != '0) outstanding_q <= outstanding_q - OutW'(1);
        default: ;
      endcase
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i)
                   dma_trans_complete_i |-> (outstanding_q != '0));

  assign reg_rvalid_o    = rvalid_q;
  assign reg_rdata_o     = rdata_q;
  assign dma_valid_o     = dma_valid_q;
  assign dma_src_o       = dma_src_q;
  assign dma_dst_o       = dma_dst_q;
  assign dma_num_bytes_o = dma_len_q;

endmodule

// File: tb/tb_mempool_dma_frontend.sv
// tb/tb_mempool_dma_frontend.sv - directed self-checking bench for mempool_dma_frontend
module tb_mempool_dma_frontend;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        reg_req_i = 1'b0;
  logic        reg_we_i = 1'b0;
  logic [4:0]  reg_addr_i = '0;
  logic [31:0] reg_wdata_i = '0;
  logic [3:0]  reg_be_i = '0;
  logic        reg_rvalid_o;
  logic [31:0] reg_rdata_o;
  logic [31:0] dma_src_o, dma_dst_o, dma_num_bytes_o;
  logic        dma_valid_o;
  logic        dma_ready_i = 1'b0;
  logic        dma_trans_complete_i = 1'b0;
  logic        dma_backend_idle_i = 1'b1;

  int checks = 0;
  int errors = 0;

  mempool_dma_frontend dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .reg_req_i(reg_req_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i), .reg_be_i(reg_be_i),
    .reg_rvalid_o(reg_rvalid_o), .reg_rdata_o(reg_rdata_o),
    .dma_src_o(dma_src_o), .dma_dst_o(dma_dst_o), .dma_num_bytes_o(dma_num_bytes_o),
    .dma_valid_o(dma_valid_o), .dma_ready_i(dma_ready_i),
    .dma_trans_complete_i(dma_trans_complete_i), .dma_backend_idle_i(dma_backend_idle_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic reg_access(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output logic [31:0] rd);
    @(negedge clk_i);
    reg_req_i = 1'b1; reg_we_i = we; reg_addr_i = addr; reg_wdata_i = wdata; reg_be_i = be;
    @(negedge clk_i);
    reg_req_i = 1'b0; reg_we_i = 1'b0;
    check("rvalid", {31'b0, reg_rvalid_o}, 32'd1);
    rd = reg_rdata_o;
  endtask

  task automatic rd_check(input string name, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    reg_access(1'b0, addr, 32'h0, 4'h0, rd);
    check(name, rd, exp);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    reg_access(1'b1, addr, wdata, 4'hF, rd);
  endtask

  task automatic do_handshake(input string name);
    @(negedge clk_i);
    dma_ready_i = 1'b1;
    @(negedge clk_i);
    dma_ready_i = 1'b0;
    check(name, {31'b0, dma_valid_o}, 32'd0);
  endtask

  task automatic pulse_complete;
    @(negedge clk_i);
    dma_trans_complete_i = 1'b1;
    @(negedge clk_i);
    dma_trans_complete_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;

    vecs.push_back('{1'b0, 5'h00, 32'h0,         4'hF, 32'h0});
    vecs.push_back('{1'b1, 5'h00, 32'h0000_0100, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 5'h00, 32'h0,         4'hF, 32'h0000_0100});
    vecs.push_back('{1'b1, 5'h04, 32'hAABB_CCDD, 4'h5, 32'h0});
    vecs.push_back('{1'b0, 5'h04, 32'h0,         4'hF, 32'h00BB_00DD});
    vecs.push_back('{1'b1, 5'h18, 32'h1234_5678, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 5'h18, 32'h0,         4'hF, 32'h0});
    vecs.push_back('{1'b1, 5'h14, 32'hFFFF_FFFF, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 5'h14, 32'h0,         4'hF, 32'h0});
    vecs.push_back('{1'b0, 5'h10, 32'h0,         4'hF, 32'h0});
    vecs.push_back('{1'b0, 5'h0C, 32'h0,         4'hF, 32'h0});
    vecs.push_back('{1'b1, 5'h04, 32'h8000_0000, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 5'h08, 32'h0000_0040, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 5'h08, 32'h0,         4'hF, 32'h0000_0040});
    vecs.push_back('{1'b0, 5'h04, 32'h0,         4'hF, 32'h8000_0000});

    #12;
    check("rst_valid", {31'b0, dma_valid_o}, 32'd0);
    check("rst_src", dma_src_o, 32'h0);
    check("rst_dst", dma_dst_o, 32'h0);
    check("rst_len", dma_num_bytes_o, 32'h0);
    check("rst_rvalid", {31'b0, reg_rvalid_o}, 32'd0);
    check("rst_rdata", reg_rdata_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      reg_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd);
      check($sformatf("vec%0d", i), rd, vecs[i].exp);
    end
    check("no_launch_len0", {31'b0, dma_valid_o}, 32'd0);
    @(negedge clk_i);
    check("idle_rvalid", {31'b0, reg_rvalid_o}, 32'd0);
    check("idle_rdata", reg_rdata_o, 32'h0);

    // Launch with five cycles of backpressure.
    rd_check("launch1_id", 5'h10, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      check("bp_valid", {31'b0, dma_valid_o}, 32'd1);
      check("bp_src", dma_src_o, 32'h0000_0100);
      check("bp_dst", dma_dst_o, 32'h8000_0000);
      check("bp_len", dma_num_bytes_o, 32'h0000_0040);
    end
    wr(5'h00, 32'h0000_0200);
    check("pending_src_kept", dma_src_o, 32'h0000_0100);
    rd_check("status_pending", 5'h0C, 32'h3);
    do_handshake("hs1_valid_fall");
    rd_check("status_after_hs", 5'h0C, 32'h1);

    // Back-to-back NEXT_ID reads.
    @(negedge clk_i);
    reg_req_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = 5'h10;
    @(negedge clk_i);
    check("b2b_first", reg_rdata_o, 32'd2);
    @(negedge clk_i);
    reg_req_i = 1'b0;
    check("b2b_second", reg_rdata_o, 32'd0);
    check("b2b_rvalid", {31'b0, reg_rvalid_o}, 32'd1);
    check("b2b_src", dma_src_o, 32'h0000_0200);
    do_handshake("b2b_hs");
    @(negedge clk_i);
    check("b2b_single_req", {31'b0, dma_valid_o}, 32'd0);

    // Outstanding limit: two more launches bring outstanding to 4.
    rd_check("launch3_id", 5'h10, 32'd3);
    do_handshake("hs3");
    rd_check("launch4_id", 5'h10, 32'd4);
    do_handshake("hs4");
    rd_check("limit_reject", 5'h10, 32'd0);
    check("limit_no_valid", {31'b0, dma_valid_o}, 32'd0);
    pulse_complete();
    rd_check("done_1", 5'h14, 32'd1);
    rd_check("launch5_id", 5'h10, 32'd5);
    do_handshake("hs5");

    // Completion and handshake in the same cycle keep outstanding at 3.
    pulse_complete();
    rd_check("launch6_id", 5'h10, 32'd6);
    @(negedge clk_i);
    dma_ready_i = 1'b1; dma_trans_complete_i = 1'b1;
    @(negedge clk_i);
    dma_ready_i = 1'b0; dma_trans_complete_i = 1'b0;
    check("same_cycle_valid", {31'b0, dma_valid_o}, 32'd0);
    rd_check("done_3", 5'h14, 32'd3);
    rd_check("launch7_id", 5'h10, 32'd7);
    do_handshake("hs7");
    rd_check("limit_reject2", 5'h10, 32'd0);

    // Asynchronous reset while a request is pending.
    pulse_complete();
    rd_check("launch8_id", 5'h10, 32'd8);
    check("pre_rst_valid", {31'b0, dma_valid_o}, 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, dma_valid_o}, 32'd0);
    check("async_rst_src", dma_src_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    rd_check("post_rst_done", 5'h14, 32'd0);
    rd_check("post_rst_len", 5'h08, 32'd0);
    dma_backend_idle_i = 1'b0;
    rd_check("status_backend_busy", 5'h0C, 32'h1);
    dma_backend_idle_i = 1'b1;
    wr(5'h08, 32'h0000_0010);
    rd_check("post_rst_id", 5'h10, 32'd1);
    check("post_rst_len_out", dma_num_bytes_o, 32'h0000_0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mempool_dma_frontend.md
Name: mempool_dma_frontend

Overview:
- Register-programmed DMA frontend that builds one burst request per launch and drives the cluster DMA request handshake.
- Tracks outstanding and completed transfers from the cluster's DMA status (trans_complete pulse, backend_idle).
- Sits between the control-register bus (peripheral crossbar) and the cluster DMA input.
- Software writes SRC, DST and LEN, then reads NEXT_ID to launch; it polls DONE or STATUS to wait.

Parameters:
- AddrWidth, 32, width of source/destination addresses and of LEN.
- DataWidth, 32, register bus data width; must equal AddrWidth.
- IdWidth, 32, width of the transfer ID and completion counters.
- MaxOutstanding, 4, maximum accepted but not yet completed transfers; must be ≥1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- reg_req_i  in  1  register access request.
- reg_we_i  in  1  1 = write.
- reg_addr_i  in  5  byte offset (word aligned).
- reg_wdata_i  in  DataWidth  write data.
- reg_be_i  in  DataWidth/8  byte enables.
- reg_rvalid_o  out  1  response valid.
- reg_rdata_o  out  DataWidth  read data.
- dma_src_o  out  AddrWidth  burst source address.
- dma_dst_o  out  AddrWidth  burst destination address.
- dma_num_bytes_o  out  AddrWidth  burst length in bytes.
- dma_valid_o  out  1  request valid.
- dma_ready_i  in  1  request accepted by the cluster.
- dma_trans_complete_i  in  1  one-cycle pulse per completed transfer.
- dma_backend_idle_i  in  1  all backends idle.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - All outputs are 0.
  - SRC, DST and LEN are 0.
  - next_id is 1; done_id is 0; outstanding is 0.
- Register map (offsets):
  - 0x00 SRC (RW).
  - 0x04 DST (RW).
  - 0x08 LEN (RW).
  - 0x0C STATUS (RO): bit0 busy = dma_valid_o | (outstanding≠0) | !dma_backend_idle_i; bit1 = dma_valid_o; other bits 0.
  - 0x10 NEXT_ID (RO, read has a side effect).
  - 0x14 DONE (RO) = done_id.
  - Other offsets read 0 and ignore writes.
- Register access rules:
  - Writes honour reg_be_i per byte.
  - Writes to RO registers are ignored.
  - Every request gets reg_rvalid_o exactly one cycle later; reg_rdata_o is registered.
  - reg_rdata_o is 0 on writes and when reg_rvalid_o is 0.
- Launch (read of NEXT_ID) is accepted only if all three hold:
  - dma_valid_o = 0,
  - LEN ≠ 0,
  - outstanding + (launch already in flight) < MaxOutstanding.
- On an accepted launch:
  - SRC/DST/LEN are copied into output registers and dma_valid_o rises on the next edge.
  - The read returns next_id, and next_id increments.
  - next_id wraps from 2^IdWidth−1 to 1; 0 is never issued.
- A rejected launch returns 0 and changes no state.
- Request handshake:
  - dma_valid_o and the payload stay stable until a cycle where dma_valid_o & dma_ready_i.
  - dma_valid_o falls after that cycle, and outstanding increments.
  - dma_valid_o never depends combinationally on dma_ready_i.
- Writes to SRC/DST/LEN while dma_valid_o=1 update the registers only; the pending payload is unchanged.
- Completion:
  - Each dma_trans_complete_i pulse increments done_id (wraps at 2^IdWidth−1 to 1, mirroring next_id) and decrements outstanding.
  - A handshake and a completion in the same cycle leave outstanding unchanged.
  - A completion with outstanding=0 is a protocol error: outstanding stays 0 (no underflow), done_id still increments, and a simulation assertion fires.
- Reset mid-operation: dma_valid_o drops immediately (asynchronously), the pending request is discarded, and all counters reset.
- Implementation notes:
  - The register read path is one flop stage.
  - The launch decision uses the current-cycle state, so back-to-back NEXT_ID reads see the pending request from the first read and the second is rejected.

Test Plan:
- Reset → all outputs 0; reading NEXT_ID with LEN=0 returns 0 and dma_valid_o stays 0.
- Launch with backpressure: SRC=0x100, DST=0x8000_0000, LEN=0x40, read NEXT_ID → returns 1. dma_valid_o=1 with the stable payload while dma_ready_i=0 for 5 cycles; handshake on cycle 6 → valid falls, STATUS=0x1.
- Back-to-back NEXT_ID reads with dma_ready_i=0 → first returns 2, second returns 0; exactly one request is issued.
- Outstanding limit (MaxOutstanding=4): 4 launches, each handshaken, no completions → fifth NEXT_ID returns 0. One trans_complete pulse → DONE=1; the next NEXT_ID succeeds.
- Completion and handshake in the same cycle → outstanding unchanged; DONE increments by 1.
- Assert reset while dma_valid_o=1 → valid drops without a clock edge; after release, NEXT_ID returns 1.
